// File: rtl/mmio_ctrl_pkg.sv
// mmio_ctrl_pkg
// Shared types and constants for the MMIO slot controller:
//   err_code_e     - error classification reported by the sticky error register
//   DEF_SLOT_MASK  - default populated-slot mask (slots 0..13 populated)
//   slot_w()       - slot-index width for a given slot count
package mmio_ctrl_pkg;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_UNMAPPED = 2'b01,
    ERR_CONFLICT = 2'b10
  } err_code_e;

  localparam logic [63:0] DEF_SLOT_MASK = 64'h0000_0000_0000_3FFF;

  // Width of the slot index field. A single-slot build still needs one bit
  // so the decode slice stays legal.
  function automatic int slot_w(input int n_slot);
    return (n_slot <= 1) ? 1 : $clog2(n_slot);
  endfunction

endpackage

// File: rtl/mmio_err_capture.sv
// mmio_err_capture
// Sticky first-error register. The first error after a clear is latched with
// its code and address; later errors are ignored until err_clr. An error that
// arrives in the same cycle as err_clr is captured (the clear makes room for it).
// Ports:
//   clk, reset   - clock, asynchronous active-high reset
//   err_vld      - an error occurs this cycle
//   err_in       - code of that error
//   err_addr_in  - bus address of that error
//   err_clr      - clear request
//   err_flag     - sticky error indicator
//   err_code     - captured error code
//   err_addr     - captured error address
module mmio_err_capture
  import mmio_ctrl_pkg::*;
#(
  parameter int ADDR_W = 21
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              err_vld,
  input  err_code_e         err_in,
  input  logic [ADDR_W-1:0] err_addr_in,
  input  logic              err_clr,
  output logic              err_flag,
  output err_code_e         err_code,
  output logic [ADDR_W-1:0] err_addr
);

  // Capture when the register is free, or when the clear frees it this cycle.
  logic take;
  assign take = err_vld & (~err_flag | err_clr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_flag <= 1'b0;
      err_code <= ERR_NONE;
      err_addr <= '0;
    end else if (take) begin
      err_flag <= 1'b1;
      err_code <= err_in;
      err_addr <= err_addr_in;
    end else if (err_clr) begin
      err_flag <= 1'b0;
      err_code <= ERR_NONE;
      err_addr <= '0;
    end
  end

endmodule

// File: rtl/mmio_ctrl_reg.sv
// mmio_ctrl_reg
// FPro-bus to per-slot MMIO decoder with registered read data, populated-slot
// masking, sticky error capture and rd/wr conflict detection.
// Optional feature: define MMIO_ACC_CNT_EN to add the saturating 32-bit access
// counter acc_cnt (cleared by err_clr). Without it the port does not exist.
// Ports:
//   clk, reset           - clock, asynchronous active-high reset
//   mmio_cs/wr/rd        - bus chip select and strobes
//   mmio_addr            - word address: [SLOT_W+REG_W-1:REG_W] slot, [REG_W-1:0] reg
//   mmio_wr_data         - write data
//   mmio_rd_data         - registered read data (latency 1)
//   mmio_rd_valid        - one-cycle pulse when mmio_rd_data updates
//   slot_cs/mem_rd/mem_wr_array - per-slot select and strobes (combinational)
//   slot_reg_addr_array  - register address broadcast to all slots
//   slot_wr_data_array   - write data broadcast to all slots
//   slot_rd_data_array   - per-slot read data
//   err_clr              - clear error state (and access counter)
//   err_flag/code/addr   - sticky first-error capture
//   acc_cnt              - access counter (MMIO_ACC_CNT_EN only)
module mmio_ctrl_reg
  import mmio_ctrl_pkg::*;
#(
  parameter int                N_SLOT        = 64,
  parameter int                REG_W         = 5,
  parameter int                ADDR_W        = 21,
  parameter int                DATA_W        = 32,
  parameter logic [63:0]       SLOT_MASK     = DEF_SLOT_MASK,
  parameter logic [DATA_W-1:0] UNMAPPED_DATA = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           mmio_cs,
  input  logic                           mmio_wr,
  input  logic                           mmio_rd,
  input  logic [ADDR_W-1:0]              mmio_addr,
  input  logic [DATA_W-1:0]              mmio_wr_data,
  output logic [DATA_W-1:0]              mmio_rd_data,
  output logic                           mmio_rd_valid,
  output logic [N_SLOT-1:0]              slot_cs_array,
  output logic [N_SLOT-1:0]              slot_mem_rd_array,
  output logic [N_SLOT-1:0]              slot_mem_wr_array,
  output logic [N_SLOT-1:0][REG_W-1:0]   slot_reg_addr_array,
  output logic [N_SLOT-1:0][DATA_W-1:0]  slot_wr_data_array,
  input  logic [N_SLOT-1:0][DATA_W-1:0]  slot_rd_data_array,
  input  logic                           err_clr,
  output logic                           err_flag,
  output logic [1:0]                     err_code,
  output logic [ADDR_W-1:0]              err_addr
`ifdef MMIO_ACC_CNT_EN
  ,
  output logic [31:0]                    acc_cnt
`endif
);

  localparam int                SLOT_W = slot_w(N_SLOT);
  localparam logic [N_SLOT-1:0] MAP    = SLOT_MASK[N_SLOT-1:0];

  // ---------------------------------------------------------------- decode
  logic [SLOT_W-1:0] slot;
  logic [REG_W-1:0]  reg_idx;
  logic              mapped;
  logic              acc_rd, acc_wr, conflict, unmapped;

  assign slot    = mmio_addr[SLOT_W+REG_W-1:REG_W];
  assign reg_idx = mmio_addr[REG_W-1:0];
  assign mapped  = MAP[slot];

  // Qualified bus operations; rd and wr together is a conflict, not an access.
  assign acc_rd   = mmio_cs &  mmio_rd & ~mmio_wr;
  assign acc_wr   = mmio_cs &  mmio_wr & ~mmio_rd;
  assign conflict = mmio_cs &  mmio_rd &  mmio_wr;
  assign unmapped = (acc_rd | acc_wr) & ~mapped;

  // Address bits above the slot field are don't-care.
  generate
    if (ADDR_W > SLOT_W + REG_W) begin : g_hi_addr
      logic unused_hi_addr;
      assign unused_hi_addr = ^mmio_addr[ADDR_W-1:SLOT_W+REG_W];
    end
  endgenerate

  // ---------------------------------------------------------- slot strobes
  // Unpopulated slots are tied off at elaboration, so they can never see a
  // select or strobe regardless of the address.
  generate
    for (genvar i = 0; i < N_SLOT; i++) begin : g_slot
      logic sel;
      assign sel                    = mmio_cs & (slot == SLOT_W'(i));
      assign slot_cs_array[i]       = MAP[i] & sel;
      assign slot_mem_rd_array[i]   = MAP[i] & sel & mmio_rd & ~mmio_wr;
      assign slot_mem_wr_array[i]   = MAP[i] & sel & mmio_wr & ~mmio_rd;
      assign slot_reg_addr_array[i] = reg_idx;
      assign slot_wr_data_array[i]  = mmio_wr_data;
    end
  endgenerate

  // ------------------------------------------------------------- read path
  logic [DATA_W-1:0] rd_mux;
  assign rd_mux = mapped ? slot_rd_data_array[slot] : UNMAPPED_DATA;

  // Valid follows the qualified read every cycle, so back-to-back reads give
  // back-to-back pulses. Data holds between reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mmio_rd_data  <= '0;
      mmio_rd_valid <= 1'b0;
    end else begin
      mmio_rd_valid <= acc_rd;
      if (acc_rd) mmio_rd_data <= rd_mux;
    end
  end

  // -------------------------------------------------------------- errors
  logic      err_vld;
  err_code_e err_in;
  err_code_e err_code_q;

  // Conflict and unmapped are mutually exclusive (unmapped needs rd^wr).
  assign err_vld = conflict | unmapped;
  assign err_in  = conflict ? ERR_CONFLICT : ERR_UNMAPPED;

  mmio_err_capture #(
    .ADDR_W (ADDR_W)
  ) u_err (
    .clk         (clk),
    .reset       (reset),
    .err_vld     (err_vld),
    .err_in      (err_in),
    .err_addr_in (mmio_addr),
    .err_clr     (err_clr),
    .err_flag    (err_flag),
    .err_code    (err_code_q),
    .err_addr    (err_addr)
  );

  assign err_code = err_code_q;

  // -------------------------------------------------------- access counter
`ifdef MMIO_ACC_CNT_EN
  // Counts every qualified read or write (unmapped included, conflicts not),
  // saturating at all-ones. A clear wins over a coincident access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      acc_cnt <= '0;
    else if (err_clr)
      acc_cnt <= '0;
    else if ((acc_rd | acc_wr) && (acc_cnt != 32'hFFFF_FFFF))
      acc_cnt <= acc_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mmio_ctrl_reg.sv
module tb_mmio_ctrl_reg;

  localparam logic [63:0] MASK = 64'h0000_0000_0000_3FFF;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  mmio_cs, mmio_wr, mmio_rd;
  logic [20:0]           mmio_addr;
  logic [31:0]           mmio_wr_data;
  logic [31:0]           mmio_rd_data;
  logic                  mmio_rd_valid;
  logic [63:0]           slot_cs_array, slot_mem_rd_array, slot_mem_wr_array;
  logic [63:0][4:0]      slot_reg_addr_array;
  logic [63:0][31:0]     slot_wr_data_array;
  logic [63:0][31:0]     slot_rd_data_array;
  logic                  err_clr;
  logic                  err_flag;
  logic [1:0]            err_code;
  logic [20:0]           err_addr;
`ifdef MMIO_ACC_CNT_EN
  logic [31:0]           acc_cnt;
`endif

  always #5 clk = ~clk;

  mmio_ctrl_reg dut (
    .clk                 (clk),
    .reset               (reset),
    .mmio_cs             (mmio_cs),
    .mmio_wr             (mmio_wr),
    .mmio_rd             (mmio_rd),
    .mmio_addr           (mmio_addr),
    .mmio_wr_data        (mmio_wr_data),
    .mmio_rd_data        (mmio_rd_data),
    .mmio_rd_valid       (mmio_rd_valid),
    .slot_cs_array       (slot_cs_array),
    .slot_mem_rd_array   (slot_mem_rd_array),
    .slot_mem_wr_array   (slot_mem_wr_array),
    .slot_reg_addr_array (slot_reg_addr_array),
    .slot_wr_data_array  (slot_wr_data_array),
    .slot_rd_data_array  (slot_rd_data_array),
    .err_clr             (err_clr),
    .err_flag            (err_flag),
    .err_code            (err_code),
    .err_addr            (err_addr)
`ifdef MMIO_ACC_CNT_EN
    ,
    .acc_cnt             (acc_cnt)
`endif
  );

  int n_tot = 0;
  int n_bad = 0;

  // Reference state: what the bus master should observe.
  logic [31:0] m_data;
  logic        m_vld;
  logic        m_flag;
  logic [1:0]  m_code;
  logic [20:0] m_addr;
  logic [31:0] m_acc;
  logic [31:0] rdarr [64];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_data = '0; m_vld = 1'b0; m_flag = 1'b0; m_code = 2'b00; m_addr = '0; m_acc = '0;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".rd_data"},  mmio_rd_data,  m_data);
    chk({tag, ".rd_valid"}, mmio_rd_valid, m_vld);
    chk({tag, ".err_flag"}, err_flag,      m_flag);
    chk({tag, ".err_code"}, err_code,      m_code);
    chk({tag, ".err_addr"}, err_addr,      m_addr);
`ifdef MMIO_ACC_CNT_EN
    chk({tag, ".acc_cnt"},  acc_cnt,       m_acc);
`endif
  endtask

  // One bus cycle: drive, check combinational strobes, clock, check registers.
  task automatic cyc(input string tag, input logic cs, input logic rd, input logic wr,
                     input logic [20:0] addr, input logic [31:0] wd, input logic clr);
    int          s, k, e;
    logic [63:0] ecs, erd, ewr;
    mmio_cs = cs; mmio_rd = rd; mmio_wr = wr; mmio_addr = addr;
    mmio_wr_data = wd; err_clr = clr;
    for (int i = 0; i < 64; i++) slot_rd_data_array[i] = rdarr[i];
    #1;
    s   = int'(addr[10:5]);
    ecs = '0;
    if (cs && MASK[s]) ecs[s] = 1'b1;
    erd = (cs && rd && !wr) ? ecs : 64'd0;
    ewr = (cs && wr && !rd) ? ecs : 64'd0;
    chk({tag, ".cs"}, slot_cs_array, ecs);
    chk({tag, ".rd"}, slot_mem_rd_array, erd);
    chk({tag, ".wr"}, slot_mem_wr_array, ewr);
    k = int'($urandom_range(0, 63));
    chk({tag, ".reg"},   slot_reg_addr_array[k], addr[4:0]);
    chk({tag, ".wdata"}, slot_wr_data_array[k],  wd);
    @(posedge clk);
    if (cs && rd && !wr) begin
      m_vld  = 1'b1;
      m_data = MASK[s] ? rdarr[s] : 32'h0;
    end else begin
      m_vld = 1'b0;
    end
    e = 0;
    if (cs && rd && wr)                   e = 2;
    else if (cs && (rd != wr) && !MASK[s]) e = 1;
    if (e != 0 && (!m_flag || clr)) begin
      m_flag = 1'b1; m_code = 2'(e); m_addr = addr;
    end else if (clr) begin
      m_flag = 1'b0; m_code = 2'b00; m_addr = '0;
    end
    if (clr)                                           m_acc = '0;
    else if (cs && (rd != wr) && m_acc != 32'hFFFF_FFFF) m_acc = m_acc + 32'd1;
    #1;
    chk_regs(tag);
  endtask

  initial begin
    logic [20:0] a;
    for (int i = 0; i < 64; i++) rdarr[i] = $urandom;
    reset = 1'b1; mmio_cs = 0; mmio_rd = 0; mmio_wr = 0; mmio_addr = '0;
    mmio_wr_data = '0; err_clr = 0; slot_rd_data_array = '0;
    model_reset();
    #1;
    chk_regs("reset");
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    chk_regs("post_reset");

    // Write slot 2 reg 3.
    cyc("wr_s2r3", 1, 0, 1, 21'h43, 32'h1234, 0);
    chk("wr_s2r3.strobe", slot_mem_wr_array, 64'h4);
    // Read slot 3, then an idle cycle so the pulse is exactly one wide.
    rdarr[3] = 32'hA5A5_0001;
    cyc("rd_s3", 1, 1, 0, 21'h60, 32'h0, 0);
    chk("rd_s3.data", mmio_rd_data, 32'hA5A5_0001);
    cyc("idle0", 0, 0, 0, 21'h60, 32'h0, 0);
    chk("idle0.valid", mmio_rd_valid, 1'b0);
    // Back-to-back reads of slots 0, 1, 2.
    rdarr[0] = 32'h10; rdarr[1] = 32'h11; rdarr[2] = 32'h12;
    cyc("b2b0", 1, 1, 0, 21'h00, 32'h0, 0);
    cyc("b2b1", 1, 1, 0, 21'h20, 32'h0, 0);
    cyc("b2b2", 1, 1, 0, 21'h40, 32'h0, 0);
    chk("b2b2.data", mmio_rd_data, 32'h12);
    // Unmapped read of slot 20.
    cyc("unm_rd", 1, 1, 0, 21'h280, 32'h0, 0);
    chk("unm_rd.err_addr", err_addr, 21'h280);
    // Clear, conflict, then a sticky check.
    cyc("clr", 0, 0, 0, 21'h0, 32'h0, 1);
    cyc("conflict", 1, 1, 1, 21'h40, 32'h0, 0);
    chk("conflict.code", err_code, 2'b10);
    cyc("sticky", 1, 1, 0, 21'h300, 32'h0, 0);
    chk("sticky.addr", err_addr, 21'h40);
    // Clear coincident with a new unmapped write.
    cyc("clr_new", 1, 0, 1, 21'h300, 32'hBEEF, 1);
    chk("clr_new.addr", err_addr, 21'h300);
    // cs low: strobes ignored entirely.
    cyc("cs_low", 0, 1, 1, 21'h280, 32'h0, 0);

    // Reset in the middle of a read pulse.
    cyc("pre_rst", 1, 1, 0, 21'h20, 32'h0, 0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk_regs("mid_rst");
    #3 reset = 1'b0;
    @(posedge clk); #1;

    // Randomized traffic, biased toward populated slots and valid accesses.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 64; i++) rdarr[i] = $urandom;
      a = 21'($urandom);
      if ($urandom_range(0, 2) != 0) a[10:5] = 6'($urandom_range(0, 13));
      cyc("rnd", $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), a,
          $urandom, $urandom_range(0, 11) == 0);
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
